// File: rtl/sdram_port_arbiter.sv
// Two-port byte arbiter in front of the SDRAM controller: serialises client reads/writes
// and periodic refreshes into single-cycle commands and returns data/ack to the owner.
module sdram_port_arbiter #(
  parameter int REFRESH_CYCLES = 780,
  parameter int AW             = 23
) (
  input  logic          clk,
  input  logic          resetn,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_din,
  output logic [7:0]    a_dout,
  output logic          a_ack,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_din,
  output logic [7:0]    b_dout,
  output logic          b_ack,

  output logic          ctl_rd,
  output logic          ctl_wr,
  output logic          ctl_refresh,
  output logic [AW-1:0] ctl_addr,
  output logic [7:0]    ctl_din,
  input  logic [7:0]    ctl_dout,
  input  logic          ctl_data_ready,
  input  logic          ctl_busy,

  output logic          refresh_overrun
);

  localparam logic [15:0] REF_LAST = 16'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;
  typedef enum logic [1:0] {OWN_A, OWN_B, OWN_REF} owner_t;

  state_t        state;
  state_t        state_nxt;
  owner_t        owner;
  owner_t        grant_owner;
  logic          grant;
  logic          done;
  logic          cmd_we;
  logic          last_b;
  logic          refresh_pending;
  logic [15:0]   ref_cnt;
  logic          ref_wrap;
  logic          ref_clear;
  logic          a_live;
  logic          b_live;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_din;

  // A port that is being acked this cycle still shows its old request; hide it.
  assign a_live    = a_req & ~a_ack;
  assign b_live    = b_req & ~b_ack;
  assign ref_wrap  = (ref_cnt == REF_LAST);
  assign ref_clear = (state == ISSUE) && (owner == OWN_REF);

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_owner = owner;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (!ctl_busy) begin
          if (refresh_pending) begin
            grant       = 1'b1;
            grant_owner = OWN_REF;
          end else if (a_live && (!b_live || last_b)) begin
            grant       = 1'b1;
            grant_owner = OWN_A;
          end else if (b_live) begin
            grant       = 1'b1;
            grant_owner = OWN_B;
          end
        end
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = GUARD;
      GUARD: state_nxt = WAIT;
      WAIT: begin
        if (owner == OWN_REF || cmd_we) done = !ctl_busy;
        else                            done = ctl_data_ready;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_we   = a_we;
    sel_addr = a_addr;
    sel_din  = a_din;
    if (grant_owner == OWN_B) begin
      sel_we   = b_we;
      sel_addr = b_addr;
      sel_din  = b_din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Grant -> registered command pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner       <= OWN_A;
      cmd_we      <= 1'b0;
      last_b      <= 1'b1;
      ctl_rd      <= 1'b0;
      ctl_wr      <= 1'b0;
      ctl_refresh <= 1'b0;
      ctl_addr    <= '0;
      ctl_din     <= '0;
    end else begin
      ctl_rd      <= 1'b0;
      ctl_wr      <= 1'b0;
      ctl_refresh <= 1'b0;
      if (grant) begin
        owner <= grant_owner;
        if (grant_owner == OWN_REF) begin
          cmd_we      <= 1'b0;
          ctl_refresh <= 1'b1;
          ctl_addr    <= '0;
          ctl_din     <= '0;
        end else begin
          cmd_we   <= sel_we;
          ctl_rd   <= !sel_we;
          ctl_wr   <= sel_we;
          ctl_addr <= sel_addr;
          ctl_din  <= sel_din;
          last_b   <= (grant_owner == OWN_B);
        end
      end
    end
  end

  // Completion -> registered ack pulse and read-data capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_ack <= done && (owner == OWN_A);
      b_ack <= done && (owner == OWN_B);
      if (done && !cmd_we && owner == OWN_A) a_dout <= ctl_dout;
      if (done && !cmd_we && owner == OWN_B) b_dout <= ctl_dout;
    end
  end

  // Refresh timer: free-running, pending never accumulates beyond one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      if (ref_wrap) ref_cnt <= '0;
      else          ref_cnt <= ref_cnt + 16'd1;
      if (ref_wrap) begin
        refresh_pending <= 1'b1;
        if (refresh_pending && !ref_clear) refresh_overrun <= 1'b1;
      end else if (ref_clear) begin
        refresh_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural controller, byte-memory reference and
// directed plus randomized client traffic on two disjoint address halves.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        a_req, a_we, b_req, b_we;
  logic [22:0] a_addr, b_addr;
  logic [7:0]  a_din, b_din, a_dout, b_dout;
  logic        a_ack, b_ack;
  logic        ctl_rd, ctl_wr, ctl_refresh;
  logic [22:0] ctl_addr;
  logic [7:0]  ctl_din, ctl_dout;
  logic        ctl_data_ready, ctl_busy;
  logic        refresh_overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.REFRESH_CYCLES(16), .AW(23)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_ack(b_ack),
    .ctl_rd(ctl_rd), .ctl_wr(ctl_wr), .ctl_refresh(ctl_refresh),
    .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_dout(ctl_dout),
    .ctl_data_ready(ctl_data_ready), .ctl_busy(ctl_busy),
    .refresh_overrun(refresh_overrun)
  );

  // Controller model: every command keeps busy high 2..5 cycles; reads return data on the last one.
  logic [7:0]  mem [0:255];
  int unsigned busy_cnt = 0;
  logic        op_rd = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        force_busy;

  always @(posedge clk) begin
    if (ctl_rd || ctl_wr || ctl_refresh) begin
      busy_cnt <= $urandom_range(5, 2);
      op_rd    <= ctl_rd;
      if (ctl_rd) rd_data <= mem[ctl_addr[7:0]];
      if (ctl_wr) mem[ctl_addr[7:0]] <= ctl_din;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign ctl_busy       = force_busy || (busy_cnt != 0);
  assign ctl_data_ready = op_rd && (busy_cnt == 1);
  assign ctl_dout       = rd_data;

  // Event log
  int   cyc = 0, n_rd = 0, n_wr = 0, n_ref = 0, n_cmd = 0;
  int   n_a_ack = 0, n_b_ack = 0, a_ack_cyc = 0, last_busy = 0;
  logic order_arr [0:63];
  int   ref_time [0:15];
  logic [7:0] last_addr = 8'h00, last_din = 8'h00;
  logic last_wr = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ctl_rd) n_rd <= n_rd + 1;
    if (ctl_wr) n_wr <= n_wr + 1;
    if (ctl_rd || ctl_wr) begin
      order_arr[n_cmd % 64] <= ctl_addr[7];
      n_cmd     <= n_cmd + 1;
      last_addr <= ctl_addr[7:0];
      last_din  <= ctl_din;
      last_wr   <= ctl_wr;
    end
    if (ctl_refresh) begin
      ref_time[n_ref % 16] <= cyc;
      n_ref <= n_ref + 1;
    end
    if (ctl_busy) last_busy <= cyc;
    if (a_ack) begin
      n_a_ack   <= n_a_ack + 1;
      a_ack_cyc <= cyc;
    end
    if (b_ack) n_b_ack <= n_b_ack + 1;
  end

  // Reference memory as seen by the clients
  logic [7:0] ref_mem [0:255];
  bit         valid [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] din);
    if (port == 0) begin
      a_req = req; a_we = we; a_addr = {15'd0, addr}; a_din = din;
    end else begin
      b_req = req; b_we = we; b_addr = {15'd0, addr}; b_din = din;
    end
  endtask

  task automatic wait_ack(input int port, output bit ok, output logic [7:0] dout);
    ok = 1'b0;
    dout = 8'h00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((port == 0) ? a_ack : b_ack) begin
        ok = 1'b1;
        dout = (port == 0) ? a_dout : b_dout;
        break;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Back-to-back randomized ops on one port with req held high throughout.
  task automatic run_stream(input int port, input int n);
    logic [7:0] base, addr, din, d;
    logic       we;
    bit         ok;
    base = (port != 0) ? 8'h80 : 8'h00;
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      we   = ($urandom_range(1, 0) == 1);
      addr = base | 8'($urandom_range(7, 0));
      din  = 8'($urandom);
      if (!valid[addr]) we = 1'b1;
      drive(port, 1'b1, we, addr, din);
      wait_ack(port, ok, d);
      check(port == 0 ? "stream_a_ack" : "stream_b_ack", 32'(ok), 32'd1);
      if (we) begin
        ref_mem[addr] = din;
        valid[addr]   = 1'b1;
      end else begin
        check(port == 0 ? "stream_a_rdata" : "stream_b_rdata", 32'(d), 32'(ref_mem[addr]));
      end
      @(posedge clk);
      #1;
    end
    drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    bit         ok, seen;
    logic [7:0] d;
    int         s, ones, r0, acks0;

    for (int i = 0; i < 256; i++) valid[i] = 1'b0;
    resetn = 1'b0;
    force_busy = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    cycles(3);

    check("rst_ctl_cmd", {29'd0, ctl_rd, ctl_wr, ctl_refresh}, 32'd0);
    check("rst_ctl_addr", 32'(ctl_addr), 32'd0);
    check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("rst_douts", {16'd0, a_dout, b_dout}, 32'd0);
    check("rst_overrun", 32'(refresh_overrun), 32'd0);

    // Long controller init with a waiting port A write
    drive(0, 1'b1, 1'b1, 8'h03, 8'h5A);
    @(posedge clk);
    #1 resetn = 1'b1;
    cycles(30000);
    check("init_no_cmd", 32'(n_rd + n_wr + n_ref), 32'd0);
    check("init_overrun", 32'(refresh_overrun), 32'd1);
    force_busy = 1'b0;
    wait_ack(0, ok, d);
    check("init_ack", 32'(ok), 32'd1);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    ref_mem[3] = 8'h5A;
    valid[3]   = 1'b1;
    cycles(20);
    check("init_one_wr", 32'(n_wr), 32'd1);

    resetn = 1'b0;
    cycles(2);
    resetn = 1'b1;
    cycles(2);
    check("overrun_cleared", 32'(refresh_overrun), 32'd0);

    // Directed write then read on port A
    drive(0, 1'b1, 1'b1, 8'h01, 8'hA5);
    wait_ack(0, ok, d);
    #1;
    check("wr_ack", 32'(ok), 32'd1);
    check("wr_cmd", {23'd0, last_wr, last_addr}, {23'd0, 1'b1, 8'h01});
    check("wr_din", 32'(last_din), 32'hA5);
    check("wr_ack_timing", 32'(a_ack_cyc), 32'(last_busy + 2));
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    ref_mem[1] = 8'hA5;
    valid[1]   = 1'b1;
    cycles(3);

    acks0 = n_b_ack;
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    wait_ack(0, ok, d);
    #1;
    check("rd_ack", 32'(ok), 32'd1);
    check("rd_cmd", {23'd0, last_wr, last_addr}, {23'd0, 1'b0, 8'h01});
    check("rd_dout", 32'(d), 32'hA5);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cycles(3);
    check("rd_no_b_ack", 32'(n_b_ack), 32'(acks0));

    // Both ports streaming: grants must alternate
    s = n_cmd;
    fork
      run_stream(0, 6);
      run_stream(1, 6);
    join
    cycles(5);
    check("rr_cmd_count", 32'(n_cmd - s), 32'd12);
    ones = 0;
    for (int i = 0; i < 12; i++) begin
      if (order_arr[(s + i) % 64]) ones++;
      if (i > 0)
        check("rr_alternate", 32'(order_arr[(s + i) % 64] ^ order_arr[(s + i - 1) % 64]), 32'd1);
    end
    check("rr_b_share", 32'(ones), 32'd6);

    // Single-port random stream on B; A must see no acks
    acks0 = n_a_ack;
    run_stream(1, 8);
    cycles(5);
    check("b_only_no_a_ack", 32'(n_a_ack), 32'(acks0));
    check("traffic_overrun", 32'(refresh_overrun), 32'd0);

    // Idle refresh cadence
    s = n_ref;
    for (int i = 0; i < 200 && n_ref < s + 4; i++) cycles(1);
    check("ref_count", 32'(n_ref >= s + 4), 32'd1);
    for (int i = 1; i < 4; i++)
      check("ref_period", 32'(ref_time[(s + i) % 16] - ref_time[(s + i - 1) % 16]), 32'd16);
    check("ref_no_overrun", 32'(refresh_overrun), 32'd0);
    force_busy = 1'b1;
    cycles(40);
    check("ref_overrun_set", 32'(refresh_overrun), 32'd1);
    force_busy = 1'b0;
    cycles(20);

    // Reset while a read is in WAIT
    r0 = n_rd;
    seen = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (n_rd != r0) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_rd_issued", 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("midrst_cmd", {29'd0, ctl_rd, ctl_wr, ctl_refresh}, 32'd0);
    check("midrst_addr", 32'(ctl_addr), 32'd0);
    check("midrst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("midrst_douts", {16'd0, a_dout, b_dout}, 32'd0);
    check("midrst_overrun", 32'(refresh_overrun), 32'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    acks0 = n_a_ack;
    cycles(2);
    resetn = 1'b1;
    cycles(40);
    check("midrst_no_ack", 32'(n_a_ack), 32'(acks0));
    check("midrst_dout_held", 32'(a_dout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Request arbiter that sits directly upstream of the `sdram` controller and drives its `rd`/`wr`/`refresh`/`addr`/`din` command inputs. It serialises two client byte ports (A and B) plus an internal periodic refresh timer into single-cycle controller commands. It tracks each command to completion using the controller's `busy` and `data_ready` outputs, then returns read data and a one-cycle acknowledge to the owning client.

## Interface
Parameters:
- `REFRESH_CYCLES`, default 780: clk cycles between refresh requests (15.6 us at 50 MHz); legal range 16..65535.
- `AW`, default 23: byte address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; same clock as the controller's `clk`.
- `resetn` in 1: asynchronous active-low reset.
- `a_req` in 1: port A request; held high until `a_ack`.
- `a_we` in 1: 1 = write, 0 = read; stable while `a_req` is high.
- `a_addr` in AW: byte address; stable while `a_req` is high.
- `a_din` in 8: write byte; stable while `a_req` is high.
- `a_dout` out 8: read byte; valid when `a_ack` is high on a read.
- `a_ack` out 1: one-cycle completion pulse.
- `b_req`, `b_we`, `b_addr`, `b_din`, `b_dout`, `b_ack`: identical to the port A signals, for port B.
- `ctl_rd`, `ctl_wr`, `ctl_refresh` out 1: one-cycle command pulses to the controller.
- `ctl_addr` out AW: command address to the controller.
- `ctl_din` out 8: write data to the controller.
- `ctl_dout` in 8: read data from the controller.
- `ctl_data_ready` in 1: controller read-data-valid pulse.
- `ctl_busy` in 1: controller busy, including power-up initialisation.
- `refresh_overrun` out 1: sticky; set when a refresh interval expires while a refresh is still pending.

## Operation
- States: IDLE, ISSUE, GUARD, WAIT.
- IDLE, `ctl_busy`=1: no grant; covers the controller's ~300 us init.
- IDLE, `ctl_busy`=0, grant priority:
  - refresh pending first;
  - otherwise the requesting port if only one requests;
  - if both request, the port not granted last (round-robin; `last_b` resets to 1, so A wins first).
  - The grantee's `we`/`addr`/`din` are latched; go to ISSUE.
- ISSUE: exactly one of `ctl_rd`/`ctl_wr`/`ctl_refresh` is high for this one cycle; `ctl_addr`/`ctl_din` carry the latched values. For refresh: `ctl_addr`=0 and the pending flag clears. Next state GUARD.
- GUARD: one cycle; `ctl_busy` and `ctl_data_ready` are ignored. Next state WAIT.
- WAIT, completion rules:
  - Read: `ctl_data_ready`=1. `ctl_dout` is captured into the owner's `x_dout` and the owner's `x_ack` pulses next cycle.
  - Write: `ctl_busy`=0. `x_ack` pulses next cycle.
  - Refresh: `ctl_busy`=0. No ack.
  - On completion, go to IDLE.
- `x_dout` holds its value until the next read completion on that port.
- A port whose `req` is still high in the cycle after its ack is treated as a new request.
- Refresh timer:
  - 16-bit counter, free-running including during init.
  - Counts 0..REFRESH_CYCLES-1, wraps, and sets `refresh_pending` on wrap.
  - Wrap while already pending: pending stays set (no accumulation) and `refresh_overrun` sets.
- Reset (async, any state, including mid-command): state=IDLE; all `ctl_*` outputs, acks, `a_dout`/`b_dout`, counter, pending and `refresh_overrun` = 0; `last_b`=1. In-flight client requests are dropped; clients re-present them after reset.

## Timing
- Commands are registered. Grant in cycle N (IDLE) → command pulse in cycle N+1 → GUARD in N+2 → WAIT from N+3.
- Ack is a registered one-cycle pulse, one cycle after the completion condition is seen in WAIT.
- Minimum request-to-ack time: 4 cycles.
- Simultaneous events:
  - Refresh wrap in the same cycle as a client grant: the client wins that cycle; the refresh is served next in IDLE.
  - `ctl_data_ready` during GUARD: ignored; the controller must not raise it within 1 cycle of `rd`.
- Exactly one command in flight at any time; no ack is ever produced for a refresh.

## Test plan
- Reset then init: `ctl_busy`=1 for 30000 cycles with `a_req`=1 → no `ctl_*` pulse; after `ctl_busy` falls, `ctl_wr` pulses exactly once.
- Port A write `a_addr`=1, `a_din`=A5 → `ctl_wr`=1 for one cycle with `ctl_addr`=1, `ctl_din`=A5; `a_ack` one cycle after `ctl_busy` falls.
- Port A read `a_addr`=1 → `ctl_rd` pulse; controller returns A5 → `a_dout`=A5 with `a_ack`=1; `b_ack` stays 0.
- `a_req` and `b_req` held continuously → grants alternate A, B, A, B; no port is starved.
- `REFRESH_CYCLES`=16, clients idle → `ctl_refresh` pulses every 16 cycles (±command latency) and `refresh_overrun` stays 0. Hold `ctl_busy`=1 for 40 cycles → `refresh_overrun`=1.
- Assert `resetn`=0 during WAIT of a read → all outputs are 0 immediately. After release, no ack arrives for the dropped read.
